lsu: RTL and testbench
======================

# lsu

Load/store unit sitting between the single-cycle datapath's memory stage and the word-wide, byte-addressed data memory. Accepts byte/halfword/word load and store requests from the core, aligns addresses to words, performs read-modify-write for sub-word stores, and sign/zero-extends sub-word loads. Drives the memory's MemWrite/din/addr inputs and consumes its combinational dout. Little-endian: memory byte at address A appears on dout[7:0] when addr=A.

## Interface
Parameters:
- ADDR_W, 32, width of core and memory address.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  core request valid; sampled only when ready=1.
- we  in  1  1=store, 0=load.
- size  in  2  00=byte, 01=half, 10=word; 11 reserved (treated as misaligned).
- sign  in  1  loads only: 1=sign-extend, 0=zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-justified for sub-word.
- ready  out  1  1 when idle and able to accept req.
- done  out  1  one-cycle pulse on completion (also on error).
- err  out  1  one-cycle pulse, with done, on misaligned request.
- rdata  out  32  load result, valid while done=1, held afterwards.
- dm_MemWrite  out  1  memory write enable.
- dm_addr  out  ADDR_W  word-aligned memory address (bits[1:0]=00).
- dm_din  out  32  memory write data.
- dm_dout  in  32  memory read data (combinational from dm_addr).

## Operation
- States: IDLE, RD, WR. ready = (state==IDLE).
- Accept (IDLE, req=1, edge E0): latch aligned address into dm_addr, byte offset off=addr[1:0], size, sign, we.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, size=11): done=1, err=1 next cycle, no memory access, stay IDLE.
  - Word store: dm_din<=wdata, go WR.
  - Any load or sub-word store: go RD.
- RD (edge E1): read dm_dout.
  - Load: rdata<=extracted lane (byte lane off, or half lane off[1]), extended per sign; done=1; go IDLE.
  - Sub-word store: dm_din<=dm_dout with lane off (byte) or off[1] (half) replaced by wdata[7:0]/[15:0]; go WR.
- WR: dm_MemWrite=1; at the next edge memory commits; done=1; go IDLE.
- dm_MemWrite is decoded from the registered state only (never from req).
- New req may be accepted in the cycle done=1 (state already IDLE).
- req while ready=0 is ignored; core must hold it.

## Timing
- Load latency: accept at E0, done high in cycle after E1 (1 cycle in RD).
- Word store: 1 cycle in WR; done after E1.
- Sub-word store: RD then WR; done after E2.
- Misaligned: done/err in cycle after E0.
- Reset (async, reset=0): state=IDLE, ready=1, done=0, err=0, rdata=0, dm_MemWrite=0, dm_addr=0, dm_din=0. Reset asserted in RD or WR aborts immediately; dm_MemWrite falls with reset, no partial write completes after reset.
- Address wrap is not handled; dm truncates upper bits.

## Structure
- Package lsu_pkg: size encodings (SZ_B, SZ_H, SZ_W), state enum (IDLE/RD/WR).
- Sub-module lsu_byte_lane: combinational extract (word, off, size, sign -> 32b) and merge (word, wdata, off, size -> 32b); instantiated once, used by both paths.
- Top holds FSM and output registers.

## Test plan
- Word store addr=0x10, wdata=0xDEADBEEF, then word load 0x10 -> one MemWrite cycle with dm_addr=0x10, dm_din=0xDEADBEEF; load rdata=0xDEADBEEF, err=0.
- After above, byte store addr=0x12 wdata=0x55 -> RD then WR, dm_din=0xDE55BEEF; lb 0x12 sign=1 -> 0x00000055.
- lb addr=0x13 sign=1 -> 0xFFFFFFDE; sign=0 -> 0x000000DE; lh addr=0x10 sign=1 -> 0xFFFFBEEF.
- sh addr=0x11 -> done=1, err=1 next cycle, dm_MemWrite never asserted, memory unchanged.
- Back-to-back: req held high with two loads -> second accepted in the cycle first's done=1; ready low only during RD.
- Pull reset low while in WR of sub-word store -> dm_MemWrite drops immediately, all outputs at reset values, ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: access-size encodings, the
// controller state type and the alignment rule used when a request is taken.
// -----------------------------------------------------------------------------
package lsu_pkg;

    // Access-size encodings as presented by the core on 'size'
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Controller states: idle, reading the target word, writing it back
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10
    } lsu_state_t;

    // A request is misaligned when the byte offset does not suit the size.
    // The reserved size encoding is always rejected.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic bad;
        case (sz)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// -----------------------------------------------------------------------------
// lsu_byte_lane
// Purely combinational lane steering for little-endian sub-word accesses.
//   i_word    : 32-bit word read from memory
//   i_wdata   : right-justified store data from the core
//   i_off     : byte offset within the word
//   i_size    : access size (SZ_B / SZ_H / SZ_W)
//   i_sign    : 1 = sign-extend loads, 0 = zero-extend
//   o_extract : load result, lane selected and extended
//   o_merge   : i_word with the addressed lane replaced by store data
// -----------------------------------------------------------------------------
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    output logic [31:0] o_extract,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte lane is chosen by the full offset, half lane by its upper bit only
    // (halfword accesses are already known to be aligned here).
    always_comb begin
        w_byte = i_word[{i_off, 3'b000} +: 8];
        w_half = i_word[{i_off[1], 4'b0000} +: 16];
        case (i_size)
            SZ_B:    o_extract = i_sign ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
            SZ_H:    o_extract = i_sign ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
            default: o_extract = i_word;
        endcase
    end

    // Read-modify-write merge: keep every lane except the one being stored.
    always_comb begin
        o_merge = i_word;
        case (i_size)
            SZ_B:    o_merge[{i_off, 3'b000} +: 8]     = i_wdata[7:0];
            SZ_H:    o_merge[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merge = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
// Load/store unit between the core memory stage and a word-wide, byte-addressed
// data memory with combinational read data.
//   clk, reset        : clock, asynchronous active-low reset
//   req/we/size/sign  : request valid, store/load, access size, load extension
//   addr, wdata       : byte address, right-justified store data
//   ready             : idle and able to take a request
//   done, err         : completion pulse, misalignment pulse (with done)
//   rdata             : load result, held after done
//   dm_MemWrite       : memory write enable (from state only)
//   dm_addr, dm_din   : word-aligned memory address, memory write data
//   dm_dout           : memory read data
// -----------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              dm_MemWrite,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    input  logic [31:0]       dm_dout
);

    lsu_state_t  r_state;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_sign;
    logic        r_we;
    logic [31:0] r_wdata;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [ADDR_W-1:0] r_dm_addr;
    logic [31:0] r_dm_din;

    logic [31:0] w_extract;
    logic [31:0] w_merge;

    lsu_byte_lane u_lane (
        .i_word    (dm_dout),
        .i_wdata   (r_wdata),
        .i_off     (r_off),
        .i_size    (r_size),
        .i_sign    (r_sign),
        .o_extract (w_extract),
        .o_merge   (w_merge)
    );

    // Write enable comes from the registered state alone, so reset drops it
    // immediately and a request can never cause a spurious write.
    assign dm_MemWrite = (r_state == WR);
    assign ready       = (r_state == IDLE);
    assign done        = r_done;
    assign err         = r_err;
    assign rdata       = r_rdata;
    assign dm_addr     = r_dm_addr;
    assign dm_din      = r_dm_din;

    // Controller: word stores skip the read, sub-word stores read then write,
    // loads finish in the read cycle. done/err are single-cycle pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_off     <= 2'b00;
            r_size    <= SZ_B;
            r_sign    <= 1'b0;
            r_we      <= 1'b0;
            r_wdata   <= 32'h0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= 32'h0;
            r_dm_addr <= '0;
            r_dm_din  <= 32'h0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_dm_addr <= {addr[ADDR_W-1:2], 2'b00};
                        r_off     <= addr[1:0];
                        r_size    <= size;
                        r_sign    <= sign;
                        r_we      <= we;
                        r_wdata   <= wdata;
                        if (is_misaligned(size, addr[1:0])) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else if (we && (size == SZ_W)) begin
                            r_dm_din <= wdata;
                            r_state  <= WR;
                        end else begin
                            r_state <= RD;
                        end
                    end
                end
                RD: begin
                    if (r_we) begin
                        r_dm_din <= w_merge;
                        r_state  <= WR;
                    end else begin
                        r_rdata <= w_extract;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                WR: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu
// Directed bench for the load/store unit with a small word memory model.
// -----------------------------------------------------------------------------
module tb_lsu;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [1:0]        size = 2'b00;
    logic              sign = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = 32'h0;
    logic              ready;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic              dm_MemWrite;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic [31:0]       dm_dout;

    logic [31:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    int          tCycles;
    int          tWrites;
    logic [31:0] tDin;
    logic [31:0] tAddr;
    logic [31:0] tRdata;
    logic        tErr;

    lsu #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .size        (size),
        .sign        (sign),
        .addr        (addr),
        .wdata       (wdata),
        .ready       (ready),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .dm_MemWrite (dm_MemWrite),
        .dm_addr     (dm_addr),
        .dm_din      (dm_din),
        .dm_dout     (dm_dout)
    );

    always #5 clk = ~clk;

    // Word memory: combinational read, write committed on the rising edge
    assign dm_dout = mem[dm_addr[7:2]];
    always @(posedge clk) begin
        if (dm_MemWrite) mem[dm_addr[7:2]] <= dm_din;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction, entered #1 after an edge with the unit idle.
    // Records latency in edges after acceptance, write cycles and write data.
    task automatic applyStimulus(input logic iwe, input logic [1:0] isize, input logic isign,
                                 input logic [31:0] iaddr, input logic [31:0] iwdata);
        we = iwe; size = isize; sign = isign; addr = iaddr; wdata = iwdata; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        tCycles = 0; tWrites = 0; tDin = 32'h0; tAddr = 32'h0;
        while (!done && tCycles < 8) begin
            if (dm_MemWrite) begin
                tWrites++;
                tDin  = dm_din;
                tAddr = dm_addr;
            end
            @(posedge clk); #1;
            tCycles++;
        end
        if (!done) checkOutput("timeout", {31'h0, done}, 32'h1);
        tRdata = rdata;
        tErr   = err;
    endtask

    initial begin
        // Reset values while reset is held low
        #3;
        checkOutput("rst_ready", {31'h0, ready}, 32'h1);
        checkOutput("rst_done", {31'h0, done}, 32'h0);
        checkOutput("rst_err", {31'h0, err}, 32'h0);
        checkOutput("rst_rdata", rdata, 32'h0);
        checkOutput("rst_memwrite", {31'h0, dm_MemWrite}, 32'h0);
        checkOutput("rst_dm_addr", dm_addr, 32'h0);
        checkOutput("rst_dm_din", dm_din, 32'h0);
        #9 reset = 1'b1;
        @(posedge clk); #1;

        // Word store then word load
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        checkOutput("sw_writes", tWrites, 32'd1);
        checkOutput("sw_addr", tAddr, 32'h10);
        checkOutput("sw_din", tDin, 32'hDEADBEEF);
        checkOutput("sw_lat", tCycles, 32'd1);
        checkOutput("sw_mem", mem[4], 32'hDEADBEEF);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checkOutput("lw_rdata", tRdata, 32'hDEADBEEF);
        checkOutput("lw_err", {31'h0, tErr}, 32'h0);
        checkOutput("lw_lat", tCycles, 32'd1);
        checkOutput("lw_writes", tWrites, 32'd0);

        // Byte store via read-modify-write
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h12, 32'h00000055);
        checkOutput("sb_lat", tCycles, 32'd2);
        checkOutput("sb_din", tDin, 32'hDE55BEEF);
        checkOutput("sb_writes", tWrites, 32'd1);

        // Sub-word loads with sign and zero extension
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
        checkOutput("lb_12_s", tRdata, 32'h00000055);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        checkOutput("lb_13_s", tRdata, 32'hFFFFFFDE);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        checkOutput("lbu_13", tRdata, 32'h000000DE);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        checkOutput("lh_10_s", tRdata, 32'hFFFFBEEF);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        checkOutput("lhu_12", tRdata, 32'h0000DE55);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        checkOutput("lb_11_s", tRdata, 32'hFFFFFFBE);

        // Misaligned requests: immediate done+err, no write
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000AAAA);
        checkOutput("sh_mis_err", {31'h0, tErr}, 32'h1);
        checkOutput("sh_mis_lat", tCycles, 32'd0);
        checkOutput("sh_mis_memwrite", {31'h0, dm_MemWrite}, 32'h0);
        @(posedge clk); #1;
        checkOutput("sh_mis_done_pulse", {31'h0, done}, 32'h0);
        checkOutput("sh_mis_err_pulse", {31'h0, err}, 32'h0);
        checkOutput("sh_mis_memwrite2", {31'h0, dm_MemWrite}, 32'h0);
        checkOutput("sh_mis_mem", mem[4], 32'hDE55BEEF);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        checkOutput("sz11_err", {31'h0, tErr}, 32'h1);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678);
        checkOutput("sw_mis_err", {31'h0, tErr}, 32'h1);
        checkOutput("sw_mis_writes", tWrites, 32'd0);
        checkOutput("sw_mis_mem", mem[4], 32'hDE55BEEF);

        // Upper-half and odd-byte stores into a second word
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF1234);
        checkOutput("sh_16_din", tDin, 32'h12343344);
        checkOutput("sh_16_lat", tCycles, 32'd2);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h15, 32'hFFFFFFAB);
        checkOutput("sb_15_din", tDin, 32'h1234AB44);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        checkOutput("lw_14", tRdata, 32'h1234AB44);

        // Back-to-back loads with req held high
        we = 1'b0; size = 2'b10; sign = 1'b0; addr = 32'h10; req = 1'b1;
        @(posedge clk); #1;
        checkOutput("b2b_ready_rd1", {31'h0, ready}, 32'h0);
        @(posedge clk); #1;
        checkOutput("b2b_done1", {31'h0, done}, 32'h1);
        checkOutput("b2b_rdata1", rdata, 32'hDE55BEEF);
        checkOutput("b2b_ready_done1", {31'h0, ready}, 32'h1);
        addr = 32'h14;
        @(posedge clk); #1;
        checkOutput("b2b_ready_rd2", {31'h0, ready}, 32'h0);
        checkOutput("b2b_done_gap", {31'h0, done}, 32'h0);
        req = 1'b0;
        @(posedge clk); #1;
        checkOutput("b2b_done2", {31'h0, done}, 32'h1);
        checkOutput("b2b_rdata2", rdata, 32'h1234AB44);

        // Reset during the write phase of a byte store
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h18, 32'hA5A5A5A5);
        we = 1'b1; size = 2'b00; sign = 1'b0; addr = 32'h19; wdata = 32'h0; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        checkOutput("rw_memwrite", {31'h0, dm_MemWrite}, 32'h1);
        checkOutput("rw_din", dm_din, 32'hA5A500A5);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_memwrite", {31'h0, dm_MemWrite}, 32'h0);
        checkOutput("abort_ready", {31'h0, ready}, 32'h1);
        checkOutput("abort_done", {31'h0, done}, 32'h0);
        checkOutput("abort_rdata", rdata, 32'h0);
        checkOutput("abort_dm_addr", dm_addr, 32'h0);
        checkOutput("abort_dm_din", dm_din, 32'h0);
        @(posedge clk); #1;
        checkOutput("abort_mem", mem[6], 32'hA5A5A5A5);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_ready", {31'h0, ready}, 32'h1);
        checkOutput("post_rst_memwrite", {31'h0, dm_MemWrite}, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
        checkOutput("post_rst_lw", tRdata, 32'hA5A5A5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
